// File: rtl/enc16to4_req_queue.sv
// Buffered 16-to-4 priority encoder: pending requests issue lowest index
// first through a one-entry valid/ready output slot.
module enc16to4_req_queue (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] REQ,
    input  logic        CLR,
    input  logic        READY,
    output logic [3:0]  OUT,
    output logic        VALID,
    output logic [15:0] PEND,
    output logic        DROP,
    output logic        IDLE
);

    logic [15:0] p_q, p_d;
    logic [3:0]  out_q, out_d;
    logic        valid_q, valid_d;
    logic        drop_q, drop_d;

    logic [15:0] low_bit;
    logic [15:0] load_mask;
    logic [3:0]  sel;
    logic        accept;
    logic        load;

    // Isolate the lowest set bit; bit 0 has highest priority.
    assign low_bit = p_q & (~p_q + 16'd1);

    always_comb begin
        sel = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (low_bit[i]) sel = sel | i[3:0];
        end
    end

    assign accept    = valid_q && READY;
    assign load      = (!valid_q || accept) && (p_q != 16'd0);
    assign load_mask = load ? low_bit : 16'd0;

    always_comb begin
        p_d     = (p_q & ~load_mask) | REQ;
        out_d   = out_q;
        valid_d = valid_q;
        drop_d  = |(REQ & p_q & ~load_mask);
        if (CLR) begin
            p_d     = 16'd0;
            valid_d = 1'b0;
            drop_d  = 1'b0;
        end else if (load) begin
            out_d   = sel;
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_q     <= 16'd0;
            out_q   <= 4'd0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            p_q     <= p_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign OUT   = out_q;
    assign VALID = valid_q;
    assign PEND  = p_q;
    assign DROP  = drop_q;
    assign IDLE  = (p_q == 16'd0) && !valid_q;

endmodule

// File: tb/tb_enc16to4_req_queue.sv
// Self-checking bench for enc16to4_req_queue: directed scenarios plus a
// randomized run against a bit-level reference model.
module tb_enc16to4_req_queue;

    logic        CLK;
    logic        RST_N;
    logic [15:0] REQ;
    logic        CLR;
    logic        READY;
    logic [3:0]  OUT;
    logic        VALID;
    logic [15:0] PEND;
    logic        DROP;
    logic        IDLE;

    int n_cmp;
    int n_bad;

    // reference model state
    logic [15:0] mp;
    logic [3:0]  mo;
    logic        mv;
    logic        md;
    int          m_merges;

    enc16to4_req_queue dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .CLR(CLR), .READY(READY),
        .OUT(OUT), .VALID(VALID), .PEND(PEND), .DROP(DROP), .IDLE(IDLE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        mp = 16'd0; mo = 4'd0; mv = 1'b0; md = 1'b0;
    endtask

    // Spec-level step: pick lowest pending index, apply request merging.
    task automatic model_step(input logic [15:0] req, input logic rdy,
                              input logic clr);
        bit acc, fr, ld;
        int s;
        logic [15:0] keep;
        acc = mv && rdy;
        fr  = !mv || acc;
        s   = -1;
        for (int i = 0; i < 16; i++)
            if (s < 0 && mp[i]) s = i;
        ld   = fr && (s >= 0);
        keep = mp;
        if (ld) keep[s] = 1'b0;
        if (clr) begin
            mp = 16'd0; mv = 1'b0; md = 1'b0;
        end else begin
            md = |(req & keep);
            m_merges += $countones(req & keep);
            mp = keep | req;
            if (ld) begin
                mo = s[3:0]; mv = 1'b1;
            end else if (acc) begin
                mv = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        REQ = 16'd0; CLR = 1'b0; READY = 1'b0;
        RST_N = 1'b0;
        #12;
        RST_N = 1'b1;
        #1;
        tick();
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #3;
        n_cmp++;
        if ({PEND, VALID, DROP, IDLE, OUT} !== {16'd0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL reset: got PEND=%h V=%b D=%b I=%b OUT=%0d want 0/0/0/1/0",
                     PEND, VALID, DROP, IDLE, OUT);
        end
        do_reset();
    endtask

    task automatic test_single();
        READY = 1'b1;
        REQ = 16'h0001;
        tick();
        REQ = 16'h0000;
        n_cmp++;
        if (PEND !== 16'h0001 || VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pend: got PEND=%h V=%b want 0001/0", PEND, VALID);
        end
        tick();
        n_cmp++;
        if (OUT !== 4'd0 || VALID !== 1'b1 || PEND !== 16'h0) begin
            n_bad++;
            $display("FAIL single_issue: got OUT=%0d V=%b PEND=%h want 0/1/0000",
                     OUT, VALID, PEND);
        end
        tick();
        n_cmp++;
        if (VALID !== 1'b0 || IDLE !== 1'b1) begin
            n_bad++;
            $display("FAIL single_idle: got V=%b I=%b want 0/1", VALID, IDLE);
        end
    endtask

    task automatic test_back_to_back();
        int exp_codes[4] = '{0, 5, 10, 15};
        READY = 1'b1;
        REQ = 16'h8421;
        tick();
        REQ = 16'h0000;
        n_cmp++;
        if (PEND !== 16'h8421) begin
            n_bad++;
            $display("FAIL b2b_pend: got %h want 8421", PEND);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (OUT !== exp_codes[k][3:0] || VALID !== 1'b1 || DROP !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_code%0d: got OUT=%0d V=%b D=%b want %0d/1/0",
                         k, OUT, VALID, DROP, exp_codes[k]);
            end
        end
        tick();
        n_cmp++;
        if (IDLE !== 1'b1 || DROP !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: got I=%b D=%b want 1/0", IDLE, DROP);
        end
    endtask

    task automatic test_hold_and_drop();
        READY = 1'b0;
        REQ = 16'h0010;
        tick();
        REQ = 16'h0000;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (OUT !== 4'd4 || VALID !== 1'b1) begin
                n_bad++;
                $display("FAIL hold%0d: got OUT=%0d V=%b want 4/1", k, OUT, VALID);
            end
        end
        REQ = 16'h0010;
        tick();
        REQ = 16'h0000;
        n_cmp++;
        if (PEND !== 16'h0010 || DROP !== 1'b0) begin
            n_bad++;
            $display("FAIL reissue_pend: got PEND=%h D=%b want 0010/0", PEND, DROP);
        end
        REQ = 16'h0010;
        tick();
        REQ = 16'h0000;
        n_cmp++;
        if (DROP !== 1'b1 || PEND !== 16'h0010) begin
            n_bad++;
            $display("FAIL merge_drop: got D=%b PEND=%h want 1/0010", DROP, PEND);
        end
        tick();
        n_cmp++;
        if (DROP !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_pulse: got D=%b want 0", DROP);
        end
        READY = 1'b1;
        tick();
        n_cmp++;
        if (OUT !== 4'd4 || VALID !== 1'b1 || PEND !== 16'h0) begin
            n_bad++;
            $display("FAIL second_issue: got OUT=%0d V=%b PEND=%h want 4/1/0000",
                     OUT, VALID, PEND);
        end
        tick();
        n_cmp++;
        if (VALID !== 1'b0 || IDLE !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_drain: got V=%b I=%b want 0/1", VALID, IDLE);
        end
    endtask

    task automatic test_clear();
        READY = 1'b0;
        REQ = 16'h0008;
        tick();
        REQ = 16'h0000;
        tick();
        REQ = 16'h00F0;
        tick();
        REQ = 16'h0000;
        n_cmp++;
        if (PEND !== 16'h00F0 || OUT !== 4'd3 || VALID !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_setup: got PEND=%h OUT=%0d V=%b want 00f0/3/1",
                     PEND, OUT, VALID);
        end
        CLR = 1'b1;
        REQ = 16'h0001;
        tick();
        CLR = 1'b0;
        REQ = 16'h0000;
        n_cmp++;
        if (PEND !== 16'h0 || VALID !== 1'b0 || DROP !== 1'b0) begin
            n_bad++;
            $display("FAIL clr: got PEND=%h V=%b D=%b want 0000/0/0", PEND, VALID, DROP);
        end
        tick();
        n_cmp++;
        if (IDLE !== 1'b1 || VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_lost: got I=%b V=%b want 1/0", IDLE, VALID);
        end
    endtask

    task automatic test_async_reset();
        READY = 1'b0;
        REQ = 16'h0001;
        tick();
        REQ = 16'h0000;
        tick();
        REQ = 16'h1234;
        tick();
        REQ = 16'h0000;
        n_cmp++;
        if (VALID !== 1'b1 || PEND !== 16'h1234) begin
            n_bad++;
            $display("FAIL arst_setup: got V=%b PEND=%h want 1/1234", VALID, PEND);
        end
        #2;
        RST_N = 1'b0;
        #1;
        n_cmp++;
        if (VALID !== 1'b0 || PEND !== 16'h0 || DROP !== 1'b0) begin
            n_bad++;
            $display("FAIL arst: got V=%b PEND=%h D=%b want 0/0000/0", VALID, PEND, DROP);
        end
        #3;
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (IDLE !== 1'b1) begin
                n_bad++;
                $display("FAIL arst_idle%0d: got I=%b want 1", k, IDLE);
            end
        end
    endtask

    task automatic test_random();
        int requested;
        int issued;
        int budget;
        do_reset();
        model_reset();
        m_merges  = 0;
        requested = 0;
        issued    = 0;
        for (int c = 0; c < 10000; c++) begin
            REQ   = 16'($urandom & $urandom & $urandom);
            READY = ($urandom_range(0, 3) != 0);
            CLR   = 1'b0;
            requested += $countones(REQ);
            if (VALID && READY) issued++;
            model_step(REQ, READY, CLR);
            tick();
            n_cmp++;
            if (PEND !== mp || VALID !== mv || DROP !== md || (mv && OUT !== mo)) begin
                n_bad++;
                $display("FAIL rand c%0d: got P=%h O=%0d V=%b D=%b want %h/%0d/%b/%b",
                         c, PEND, OUT, VALID, DROP, mp, mo, mv, md);
            end
        end
        REQ   = 16'h0;
        READY = 1'b1;
        budget = 0;
        while ((mp != 16'h0 || mv) && budget < 100) begin
            if (VALID && READY) issued++;
            model_step(REQ, READY, CLR);
            tick();
            budget++;
        end
        n_cmp++;
        if (IDLE !== 1'b1 || budget >= 100) begin
            n_bad++;
            $display("FAIL rand_drain: got I=%b after %0d cycles want 1", IDLE, budget);
        end
        n_cmp++;
        if (issued + m_merges != requested) begin
            n_bad++;
            $display("FAIL rand_account: got issued+merges=%0d want %0d",
                     issued + m_merges, requested);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        REQ = 16'd0; CLR = 1'b0; READY = 1'b0; RST_N = 1'b1;
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_and_drop();
        test_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
